cordic_addsub_sched: RTL and testbench
======================================

Name: cordic_addsub_sched

Overview:
- Iterative CORDIC sequencer that time-multiplexes one external combinational Add_Sub unit (width DW) across the x, y and z updates of every iteration.
- Accepts an (x, y, z) vector over a valid/ready handshake and runs ITER micro-rotations of three phases each.
- Fetches arctangent constants from an external ROM and returns the result over a valid/ready handshake.
- Sits between the pipeline front end and the shared datapath adder.

Parameters:
DW, 16, datapath width for x/y/z, the Add_Sub operands and atan_val; two's complement.
ITER, 14, number of CORDIC iterations; legal range 1..DW.
IW, $clog2(ITER) (min 1), width of atan_idx and of the iteration counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input vector valid.
in_ready  out  1  high only in IDLE.
x_in, y_in, z_in  in  DW each  input vector and angle.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  result consumer ready.
x_out, y_out, z_out  out  DW each  result registers.
busy  out  1  high in PX, PY, PZ and DONE.
as_a, as_b  out  DW each  operands to the shared Add_Sub.
as_add  out  1  Add_Sub select: 1 = add, 0 = subtract.
as_c  in  DW  Add_Sub result; combinational in the same cycle.
atan_idx  out  IW  current iteration index i to the atan ROM.
atan_val  in  DW  atan(2^-i) in z units; combinational.

Behaviour:
- Reset: asserting rst_n low, including mid-operation, immediately forces the following; any in-flight vector is discarded.
  - State = IDLE; x, y, z, tmp and i = 0.
  - out_valid = 0, busy = 0, in_ready = 1.
  - x_out, y_out, z_out = 0; as_a = as_b = 0; as_add = 1; atan_idx = 0.
- States: IDLE, PX, PY, PZ, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load x, y, z from the inputs, set i = 0, go to PX.
- Direction: sigma = +1 when z[DW-1] == 0, else -1.
  - sigma is evaluated once, when entering PX, and held for PX/PY/PZ of that iteration.
- PX (one cycle):
  - as_a = x; as_b = y >>> i (arithmetic shift); as_add = (sigma == -1).
  - tmp <= as_c.
- PY (one cycle):
  - as_a = y; as_b = x >>> i; as_add = (sigma == +1).
  - y <= as_c; x <= tmp.
  - Old x is used as the shift source because x is committed only on this edge.
- PZ (one cycle):
  - as_a = z; as_b = atan_val; as_add = (sigma == -1).
  - z <= as_c.
  - If i == ITER-1: go to DONE, and x_out/y_out/z_out <= final x/y/z.
  - Else: i <= i+1, go to PX.
- DONE:
  - out_valid = 1; outputs stable.
  - On out_ready: go to IDLE. No new vector is accepted in the same cycle; in_ready rises the next cycle.
  - x_out/y_out/z_out hold their values after leaving DONE until the next result is written.
- Outside PX/PY/PZ: as_a = as_b = 0, as_add = 1.
- atan_idx = i at all times.
- Latency: out_valid rises exactly 3*ITER cycles after the acceptance edge (42 for ITER = 14).
- Throughput: one vector per 3*ITER + 2 cycles, minimum.
- Arithmetic:
  - All sums wrap modulo 2^DW, no saturation.
  - Shift by i >= DW-1 yields all sign bits (0 or -1).
  - The CORDIC gain K is not compensated.
- Input side: in_valid while not in IDLE is ignored; inputs are not sampled.
- Output side: out_ready while not in DONE is ignored.

Optional Feature:
- Macro CORDIC_VECTORING_EN.
- Defined:
  - Adds input port mode (1 bit), sampled with the input vector on the acceptance edge.
  - mode = 0 selects rotation: sigma from z, as above.
  - mode = 1 selects vectoring: sigma = +1 when y[DW-1] == 1, else -1, evaluated when entering PX.
- Undefined: the mode port is absent and the block is rotation-only.
- Timing and handshakes are identical in both builds.

Test Plan:
1. Reset, then x=0x4000, y=0, z=0 (DW=16, ITER=14) -> on the first PX cycle as_a=0x4000, as_b=0x0000, as_add=0; out_valid exactly 42 cycles after acceptance; outputs bit-exact with the bench golden model (|y_out| <= 14 LSB).
2. z=0x8000 (negative) -> first PX as_add=1, PY as_add=0, PZ as_add=1 with as_b=atan_val for idx 0; outputs bit-exact with the model.
3. Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; pulse out_ready -> IDLE and in_ready=1 the next cycle. in_valid pulses during busy cause no restart.
4. Assert rst_n low during iteration 5, PY phase -> immediately out_valid=0, busy=0, in_ready=1, outputs 0; a fresh vector then completes in 42 cycles, bit-exact.
5. x=0x7FFF, y=0x7FFF, z=0 -> wrap-around occurs without flagging; outputs match the model's modulo-2^16 arithmetic. Also run ITER=16 to exercise shift by 15 (0 or 0xFFFF operand).
6. CORDIC_VECTORING_EN defined, mode=1, x=0x3000, y=0x3000, z=0 -> y_out within 14 LSB of 0 and z_out ≈ atan(1) in z units, bit-exact with the model.

Source files
------------

// File: rtl/cordic_addsub_sched.sv
// Iterative CORDIC sequencer sharing one external combinational Add_Sub across the x, y and z phases.
// Optional feature macro: CORDIC_VECTORING_EN adds the mode input (0 = rotation, 1 = vectoring).
module cordic_addsub_sched #(
  parameter int DW   = 16,
  parameter int ITER = 14,
  parameter int IW   = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic [DW-1:0] z_in,
`ifdef CORDIC_VECTORING_EN
  input  logic          mode,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] z_out,
  output logic          busy,
  output logic [DW-1:0] as_a,
  output logic [DW-1:0] as_b,
  output logic          as_add,
  input  logic [DW-1:0] as_c,
  output logic [IW-1:0] atan_idx,
  input  logic [DW-1:0] atan_val
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PX   = 3'd1,
    S_PY   = 3'd2,
    S_PZ   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] x_r, y_r, z_r, tmp_r;
  logic [IW-1:0] i_r;
  logic          sigma_neg_r;
  logic          vec_r;
  logic          vec_in_s;
  logic          last_s;

  function automatic logic [DW-1:0] asr(input logic [DW-1:0] v, input logic [IW-1:0] sh);
    asr = DW'($signed(v) >>> sh);
  endfunction

  // Rotation steers by the sign of z, vectoring drives y toward zero.
  function automatic logic sigma_neg(input logic vec, input logic [DW-1:0] zv, input logic [DW-1:0] yv);
    sigma_neg = vec ? ~yv[DW-1] : zv[DW-1];
  endfunction

`ifdef CORDIC_VECTORING_EN
  assign vec_in_s = mode;
`else
  assign vec_in_s = 1'b0;
`endif

  assign last_s    = (i_r == IW'(ITER - 1));
  assign in_ready  = (state_r == S_IDLE);
  assign out_valid = (state_r == S_DONE);
  assign busy      = (state_r != S_IDLE);
  assign atan_idx  = i_r;

  // Next-state selection and Add_Sub operand steering for the current phase.
  always_comb begin
    state_s = state_r;
    as_a    = '0;
    as_b    = '0;
    as_add  = 1'b1;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_s = S_PX;
        else          state_s = S_IDLE;
      end
      S_PX: begin
        as_a    = x_r;
        as_b    = asr(y_r, i_r);
        as_add  = sigma_neg_r;
        state_s = S_PY;
      end
      S_PY: begin
        as_a    = y_r;
        as_b    = asr(x_r, i_r);
        as_add  = ~sigma_neg_r;
        state_s = S_PZ;
      end
      S_PZ: begin
        as_a   = z_r;
        as_b   = atan_val;
        as_add = sigma_neg_r;
        if (last_s) state_s = S_DONE;
        else        state_s = S_PX;
      end
      S_DONE: begin
        if (out_ready) state_s = S_IDLE;
        else           state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Vector registers, iteration counter, held direction and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      tmp_r       <= '0;
      i_r         <= '0;
      sigma_neg_r <= 1'b0;
      vec_r       <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      z_out       <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            x_r         <= x_in;
            y_r         <= y_in;
            z_r         <= z_in;
            i_r         <= '0;
            vec_r       <= vec_in_s;
            sigma_neg_r <= sigma_neg(vec_in_s, z_in, y_in);
          end
        end
        S_PX: tmp_r <= as_c;
        // x commits only here so PY can still shift the old x.
        S_PY: begin
          x_r <= tmp_r;
          y_r <= as_c;
        end
        S_PZ: begin
          z_r <= as_c;
          if (last_s) begin
            x_out <= x_r;
            y_out <= y_r;
            z_out <= as_c;
          end else begin
            i_r         <= i_r + IW'(1);
            sigma_neg_r <= sigma_neg(vec_r, as_c, y_r);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_addsub_sched.sv
// Self-checking bench for cordic_addsub_sched: random and directed vectors against a plain CORDIC loop model.
module tb_cordic_addsub_sched;
  localparam int ITER = 14;
  localparam int LAT  = 3 * ITER;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, mode;
  logic [15:0] x_in, y_in, z_in;
  logic        in_ready, out_valid, busy, as_add;
  logic [15:0] x_out, y_out, z_out, as_a, as_b, as_c, atan_val;
  logic [3:0]  atan_idx;

  logic        in_valid16, out_ready16, in_ready16, out_valid16, busy16, as_add16;
  logic [15:0] x_out16, y_out16, z_out16, as_a16, as_b16, as_c16, atan_val16;
  logic [3:0]  atan_idx16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] atan_rom(input int i);
    case (i)
      0: atan_rom = 16'd8192;   1: atan_rom = 16'd4836;   2: atan_rom = 16'd2555;
      3: atan_rom = 16'd1297;   4: atan_rom = 16'd651;    5: atan_rom = 16'd326;
      6: atan_rom = 16'd163;    7: atan_rom = 16'd81;     8: atan_rom = 16'd41;
      9: atan_rom = 16'd20;    10: atan_rom = 16'd10;    11: atan_rom = 16'd5;
      12: atan_rom = 16'd3;    13: atan_rom = 16'd1;     14: atan_rom = 16'd1;
      default: atan_rom = 16'd0;
    endcase
  endfunction

  assign as_c       = as_add ? as_a + as_b : as_a - as_b;
  assign atan_val   = atan_rom(int'(atan_idx));
  assign as_c16     = as_add16 ? as_a16 + as_b16 : as_a16 - as_b16;
  assign atan_val16 = atan_rom(int'(atan_idx16));

  cordic_addsub_sched #(.DW(16), .ITER(ITER)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
`ifdef CORDIC_VECTORING_EN
    .mode(mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy),
    .as_a(as_a), .as_b(as_b), .as_add(as_add), .as_c(as_c),
    .atan_idx(atan_idx), .atan_val(atan_val)
  );

  cordic_addsub_sched #(.DW(16), .ITER(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
`ifdef CORDIC_VECTORING_EN
    .mode(mode),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .x_out(x_out16), .y_out(y_out16), .z_out(z_out16), .busy(busy16),
    .as_a(as_a16), .as_b(as_b16), .as_add(as_add16), .as_c(as_c16),
    .atan_idx(atan_idx16), .atan_val(atan_val16)
  );

  // Textbook CORDIC micro-rotations in wrapping 16-bit arithmetic.
  task automatic model(input logic [15:0] xi, yi, zi, input logic md, input int iters,
                       output logic [15:0] xo, yo, zo);
    logic signed [15:0] x, y, z, xs, ys;
    int sg;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < iters; i++) begin
      if (md) sg = (y < 0) ? 1 : -1;
      else    sg = (z < 0) ? -1 : 1;
      xs = x >>> i;
      ys = y >>> i;
      if (sg == 1) begin
        x = x - ys; y = y + xs; z = z - $signed(atan_rom(i));
      end else begin
        x = x + ys; y = y - xs; z = z + $signed(atan_rom(i));
      end
    end
    xo = x; yo = y; zo = z;
  endtask

  task automatic run_vec(input logic [15:0] xi, yi, zi, input logic md, input bit noise, input int hold,
                         output logic [15:0] xo, yo, zo, output logic [15:0] pa, pb,
                         output logic pxadd, pyadd, pzadd, output logic [15:0] pzb, output int lat);
    @(negedge clk);
    x_in = xi; y_in = yi; z_in = zi; mode = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pa = as_a; pb = as_b; pxadd = as_add;
    pyadd = 1'bx; pzadd = 1'bx; pzb = 16'hxxxx;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) pyadd = as_add;
      if (lat == 2) begin pzadd = as_add; pzb = as_b; end
      if (noise && lat == 5) begin
        in_valid = 1'b1; x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      end
      if (noise && lat == 6) in_valid = 1'b0;
    end
    xo = x_out; yo = y_out; zo = z_out;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== xo || y_out !== yo || z_out !== zo) begin
        failures++;
        $display("FAIL hold_stable cycle %0d: valid=%b ready=%b out=%h/%h/%h expected valid=1 ready=0 out=%h/%h/%h",
                 k, out_valid, in_ready, x_out, y_out, z_out, xo, yo, zo);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== xo || y_out !== yo || z_out !== zo) begin
      failures++;
      $display("FAIL release_idle: busy=%b ready=%b valid=%b out=%h/%h/%h expected 0/1/0 out=%h/%h/%h",
               busy, in_ready, out_valid, x_out, y_out, z_out, xo, yo, zo);
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] xi, yi, zi, input logic md,
                              input logic [15:0] xo, yo, zo, input int lat);
    logic [15:0] ex, ey, ez;
    model(xi, yi, zi, md, ITER, ex, ey, ez);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
    end
    checks++;
    if (xo !== ex || yo !== ey || zo !== ez) begin
      failures++;
      $display("FAIL %s_result: got %h/%h/%h expected %h/%h/%h", name, xo, yo, zo, ex, ey, ez);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    x_in = 16'h0000; y_in = 16'h0000; z_in = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: valid=%b busy=%b ready=%b expected 0/0/1", out_valid, busy, in_ready);
    end
    checks++;
    if (x_out !== 16'h0000 || y_out !== 16'h0000 || z_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got %h/%h/%h expected 0000/0000/0000", x_out, y_out, z_out);
    end
    checks++;
    if (as_a !== 16'h0000 || as_b !== 16'h0000 || as_add !== 1'b1 || atan_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_addsub: a=%h b=%h add=%b idx=%0d expected 0000/0000/1/0", as_a, as_b, as_add, atan_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza; int lat;
    run_vec(16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
    checks++;
    if (pa !== 16'h4000 || pb !== 16'h0000 || pxa !== 1'b0) begin
      failures++;
      $display("FAIL basic_px: a=%h b=%h add=%b expected 4000/0000/0", pa, pb, pxa);
    end
    check_result("basic", 16'h4000, 16'h0000, 16'h0000, 1'b0, xo, yo, zo, lat);
    checks++;
    if ($signed(yo) > 64 || $signed(yo) < -64) begin
      failures++;
      $display("FAIL basic_y_near_zero: got %0d expected |y| <= 64", $signed(yo));
    end
  endtask

  task automatic test_negz();
    logic [15:0] xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza; int lat;
    run_vec(16'h4000, 16'h1000, 16'h8000, 1'b0, 1'b0, 0, xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
    checks++;
    if (pxa !== 1'b1 || pya !== 1'b0 || pza !== 1'b1 || pzb !== atan_rom(0)) begin
      failures++;
      $display("FAIL negz_dir: px=%b py=%b pz=%b pzb=%h expected 1/0/1/%h", pxa, pya, pza, pzb, atan_rom(0));
    end
    check_result("negz", 16'h4000, 16'h1000, 16'h8000, 1'b0, xo, yo, zo, lat);
  endtask

  task automatic test_hold_ignore();
    logic [15:0] xi, yi, zi, xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza; int lat;
    xi = 16'($urandom); yi = 16'($urandom); zi = 16'($urandom);
    run_vec(xi, yi, zi, 1'b0, 1'b1, 10, xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
    check_result("hold", xi, yi, zi, 1'b0, xo, yo, zo, lat);
  endtask

  task automatic test_reset_mid();
    logic [15:0] xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza; int lat;
    @(negedge clk);
    x_in = 16'h2345; y_in = 16'h1111; z_in = 16'h0800; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (atan_idx !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_position: idx=%0d busy=%b expected 5/1", atan_idx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || x_out !== 16'h0000 ||
        y_out !== 16'h0000 || z_out !== 16'h0000 || as_add !== 1'b1 || atan_idx !== 4'd0) begin
      failures++;
      $display("FAIL midrst_state: valid=%b busy=%b ready=%b out=%h/%h/%h add=%b idx=%0d expected 0/0/1 0000s 1 0",
               out_valid, busy, in_ready, x_out, y_out, z_out, as_add, atan_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(16'h1357, 16'hF000, 16'h3000, 1'b0, 1'b0, 0, xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
    check_result("midrst_fresh", 16'h1357, 16'hF000, 16'h3000, 1'b0, xo, yo, zo, lat);
  endtask

  task automatic test_wrap();
    logic [15:0] xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza; int lat;
    run_vec(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 0, xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
    check_result("wrap", 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, xo, yo, zo, lat);
  endtask

  task automatic test_iter16();
    logic [15:0] vx [2], vy [2], vz [2];
    logic [15:0] ex, ey, ez, b15;
    int lat;
    logic [3:0] idx15;
    vx[0] = 16'h1234; vy[0] = 16'hC000; vz[0] = 16'h0100;
    vx[1] = 16'($urandom); vy[1] = 16'($urandom); vz[1] = 16'($urandom);
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      x_in = vx[v]; y_in = vy[v]; z_in = vz[v]; mode = 1'b0; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      lat = 0; b15 = 16'h1234; idx15 = 4'd0;
      while (out_valid16 !== 1'b1 && lat < 200) begin
        @(posedge clk); #1;
        lat++;
        if (lat == 45) begin b15 = as_b16; idx15 = atan_idx16; end
      end
      model(vx[v], vy[v], vz[v], 1'b0, 16, ex, ey, ez);
      checks++;
      if (idx15 !== 4'd15 || (b15 !== 16'h0000 && b15 !== 16'hFFFF)) begin
        failures++;
        $display("FAIL iter16_shift15: idx=%0d as_b=%h expected 15 and 0000 or ffff", idx15, b15);
      end
      checks++;
      if (lat !== 48 || x_out16 !== ex || y_out16 !== ey || z_out16 !== ez) begin
        failures++;
        $display("FAIL iter16_result: lat=%0d out=%h/%h/%h expected 48 %h/%h/%h", lat, x_out16, y_out16, z_out16, ex, ey, ez);
      end
      @(negedge clk); out_ready16 = 1'b1;
      @(negedge clk); out_ready16 = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [15:0] xi, yi, zi, xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza, md; int lat;
    for (int n = 0; n < 6; n++) begin
      xi = 16'($urandom); yi = 16'($urandom); zi = 16'($urandom);
`ifdef CORDIC_VECTORING_EN
      md = 1'($urandom_range(0, 1));
`else
      md = 1'b0;
`endif
      run_vec(xi, yi, zi, md, 1'b0, $urandom_range(0, 3), xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
      check_result("random", xi, yi, zi, md, xo, yo, zo, lat);
    end
  endtask

`ifdef CORDIC_VECTORING_EN
  task automatic test_vectoring();
    logic [15:0] xo, yo, zo, pa, pb, pzb; logic pxa, pya, pza; int lat;
    run_vec(16'h3000, 16'h3000, 16'h0000, 1'b1, 1'b0, 0, xo, yo, zo, pa, pb, pxa, pya, pza, pzb, lat);
    check_result("vectoring", 16'h3000, 16'h3000, 16'h0000, 1'b1, xo, yo, zo, lat);
    checks++;
    if ($signed(yo) > 64 || $signed(yo) < -64 || $signed(zo) > 8256 || $signed(zo) < 8128) begin
      failures++;
      $display("FAIL vectoring_converge: y=%0d z=%0d expected |y| <= 64, z near 8192", $signed(yo), $signed(zo));
    end
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_negz();
    test_hold_ignore();
    test_reset_mid();
    test_wrap();
    test_iter16();
    test_random();
`ifdef CORDIC_VECTORING_EN
    test_vectoring();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
